tlb_op_ctrl: RTL and testbench
==============================

# tlb_op_ctrl

Sequencer for the LoongArch TLB maintenance instructions TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB. It sits between the MEM-stage instruction issue and the `tlb_` array. It owns the array's read, write and flush ports and time-shares search port 1 between MEM-stage data lookups and TLBSRCH. It returns results for CSR update and raises a refetch pulse whenever TLB contents change.

## Interface
- TLBNUM, 16 (from `csr_tlbDefines`, power of two): number of TLB entries.
- TLBNUMSIZE, 4 (from `csr_tlbDefines`): index width.
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low).
- op_valid / op_ready  in / out  1 / 1  op handshake; accepted when both are high.
- op_code  in  3  0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV; 5-7 illegal.
- inv_op  in  5  INVTLB op; 0-6 legal.
- inv_asid / inv_vppn  in  10 / 19  INVTLB operands.
- csr_index  in  TLBNUMSIZE  TLBIDX.Index.
- csr_ps, csr_ne, csr_asid, csr_vppn, csr_g  in  6, 1, 10, 19, 1  TLBIDX/ASID/TLBEHI fields.
- csr_pt0 / csr_pt1  in  PhytranItem  TLBELO0/1.
- csr_tlbrefill  in  1  ESTAT.Ecode==0x3F; forces written E=1.
- mem_s_valid, mem_s_vppn, mem_s_asid, mem_s_odd  in  1, 19, 10, 1  MEM-stage lookup request.
- mem_s_stall  out  1  MEM lookup not served this cycle.
- tlb_s1_vppn, tlb_s1_asid, tlb_s1_odd  out  19, 10, 1  search port 1 drive.
- tlb_s1_index, tlb_s1_ne  in  TLBNUMSIZE, 1  search port 1 result.
- tlb_r_index  out  TLBNUMSIZE; tlb_r_ps/asid/ne/g/vppn/phytran0/phytran1  in: read port.
- tlb_we, tlb_w_index, tlb_w_ps/ne/asid/vppn/g/phytran0/phytran1  out: write port.
- tlb_fe, tlb_f_op(3), tlb_f_asid(10), tlb_f_va(19)  out: flush port.
- done, err  out  1  one-cycle completion pulse; err marks an illegal op.
- srch_hit, srch_index  out  1, TLBNUMSIZE  TLBSRCH result, valid with done.
- rd_ps, rd_ne, rd_asid, rd_vppn, rd_g, rd_pt0, rd_pt1  out: TLBRD result, valid with done.
- refetch  out  1  one-cycle pulse with done for WR, FILL and legal INV.

## Operation
- FSM states: IDLE, EXEC, DONE. op_ready = (state==IDLE).
- IDLE: on accept, register op_code, inv_*, and all csr_* fields. Capture fill_idx for FILL. Go to EXEC.
- EXEC, by op:
  - SRCH: s1 is driven with the captured csr_vppn/csr_asid and odd=0. mem_s_stall = mem_s_valid. Register hit = !tlb_s1_ne and the index.
  - RD: r_index = captured index. Register tlb_r_*. If tlb_r_ne=1, the rd_* outputs are ne=1 with all other fields zero.
  - WR: we=1 with w_index = captured index.
  - FILL: we=1 with w_index = captured fill_idx.
  - WR/FILL write data: w_ne = captured ne & !tlbrefill.
  - INV: if inv_op ≤ 6, fe=1 with f_op = inv_op[2:0]. Otherwise no fe.
  - Illegal op_code: no port activity.
  - All ops go to DONE.
- DONE: done=1. err=1 for illegal op_code or inv_op>6. refetch=1 for WR, FILL and legal INV. Go to IDLE.
- Outside SRCH-EXEC, s1 passes mem_s_* straight through and mem_s_stall=0.
- fill_idx: free-running TLBNUMSIZE counter. Increments every cycle and wraps TLBNUM-1→0.

## Timing
- Accept in cycle N. Port action (we/fe/s1/r) in N+1. done in N+2. Next accept earliest at N+3.
- we and fe are single-cycle pulses, registered-state decoded, and never both high in one cycle.
- Results hold until the next done. done, err and refetch are 0 outside DONE.
- Reset (reset==0 at clk edge) → IDLE, fill_idx=0. All outputs 0: done, err, refetch, we, fe, srch_hit, srch_index, rd_*, mem_s_stall. op_ready becomes 1 in the first cycle after reset releases.
- Reset sampled in EXEC aborts the op: no we/fe pulse occurs in the following cycle and no done is produced.
- The TLB write/flush lands at the end of N+1. A MEM lookup in N+2 sees the new contents.

## Test plan
- SRCH hit and stall: TLBSRCH with vppn=0x12345, asid=5, matching entry at index 7, mem_s_valid=1 throughout → mem_s_stall=1 only in N+1; done at N+2 with srch_hit=1, srch_index=7.
- Invalid-entry read: TLBRD at index 3 on an invalid entry → rd_ne=1, rd_asid=0, rd_vppn=0, done at N+2, refetch=0.
- WR then SRCH: TLBWR index 2 with csr_ne=1, csr_tlbrefill=1 → w_ne=0, refetch=1. A following TLBSRCH of the same vppn hits index 2.
- FILL wrap: FILL accepted with fill_idx=15 → w_index=15. Counter reads 0 the next cycle.
- INVTLB ops: INV op 2 → fe=1, f_op=2, refetch=1. INV op 9 → no fe, err=1, refetch=0. op_code 6 → done with err=1.
- Reset mid-op: reset low during EXEC of a WR → no we pulse after reset is sampled, no done, op_ready=1 in the first cycle after reset releases.

Source files
------------

// File: rtl/tlb_op_ctrl_if.sv
// Op request/response bundle between the MEM-stage issue logic and the TLB
// maintenance sequencer: handshake, INVTLB operands, CSR snapshot fields and
// the completion/result signals returned for CSR update.
// Phytran items are packed {ppn[19:0], plv[1:0], mat[1:0], d, v}.
interface tlb_op_ctrl_if #(
  parameter int TLBNUMSIZE = 4,
  parameter int PT_W       = 26
);
  // request side
  logic                  op_valid;
  logic                  op_ready;
  logic [2:0]            op_code;
  logic [4:0]            inv_op;
  logic [9:0]            inv_asid;
  logic [18:0]           inv_vppn;
  logic [TLBNUMSIZE-1:0] csr_index;
  logic [5:0]            csr_ps;
  logic                  csr_ne;
  logic [9:0]            csr_asid;
  logic [18:0]           csr_vppn;
  logic                  csr_g;
  logic [PT_W-1:0]       csr_pt0;
  logic [PT_W-1:0]       csr_pt1;
  logic                  csr_tlbrefill;

  // completion / result side
  logic                  done;
  logic                  err;
  logic                  refetch;
  logic                  srch_hit;
  logic [TLBNUMSIZE-1:0] srch_index;
  logic [5:0]            rd_ps;
  logic                  rd_ne;
  logic [9:0]            rd_asid;
  logic [18:0]           rd_vppn;
  logic                  rd_g;
  logic [PT_W-1:0]       rd_pt0;
  logic [PT_W-1:0]       rd_pt1;

  modport master (
    output op_valid, op_code, inv_op, inv_asid, inv_vppn,
           csr_index, csr_ps, csr_ne, csr_asid, csr_vppn, csr_g,
           csr_pt0, csr_pt1, csr_tlbrefill,
    input  op_ready, done, err, refetch, srch_hit, srch_index,
           rd_ps, rd_ne, rd_asid, rd_vppn, rd_g, rd_pt0, rd_pt1
  );

  modport slave (
    input  op_valid, op_code, inv_op, inv_asid, inv_vppn,
           csr_index, csr_ps, csr_ne, csr_asid, csr_vppn, csr_g,
           csr_pt0, csr_pt1, csr_tlbrefill,
    output op_ready, done, err, refetch, srch_hit, srch_index,
           rd_ps, rd_ne, rd_asid, rd_vppn, rd_g, rd_pt0, rd_pt1
  );
endinterface

// File: rtl/tlb_op_ctrl.sv
// TLB maintenance sequencer (TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB).
// Three-state sequence: accept and snapshot operands, drive exactly one TLB
// port for one cycle, then pulse done with results. Search port 1 is lent to
// TLBSRCH for its execute cycle and otherwise passes MEM lookups through.
module tlb_op_ctrl #(
  parameter int TLBNUM     = 16,
  parameter int TLBNUMSIZE = 4,
  parameter int PT_W       = 26
) (
  input  logic                  clk,
  input  logic                  reset,

  tlb_op_ctrl_if.slave          ctl,

  // MEM-stage lookup request
  input  logic                  mem_s_valid,
  input  logic [18:0]           mem_s_vppn,
  input  logic [9:0]            mem_s_asid,
  input  logic                  mem_s_odd,
  output logic                  mem_s_stall,

  // search port 1
  output logic [18:0]           tlb_s1_vppn,
  output logic [9:0]            tlb_s1_asid,
  output logic                  tlb_s1_odd,
  input  logic [TLBNUMSIZE-1:0] tlb_s1_index,
  input  logic                  tlb_s1_ne,

  // read port
  output logic [TLBNUMSIZE-1:0] tlb_r_index,
  input  logic [5:0]            tlb_r_ps,
  input  logic [9:0]            tlb_r_asid,
  input  logic                  tlb_r_ne,
  input  logic                  tlb_r_g,
  input  logic [18:0]           tlb_r_vppn,
  input  logic [PT_W-1:0]       tlb_r_phytran0,
  input  logic [PT_W-1:0]       tlb_r_phytran1,

  // write port
  output logic                  tlb_we,
  output logic [TLBNUMSIZE-1:0] tlb_w_index,
  output logic [5:0]            tlb_w_ps,
  output logic                  tlb_w_ne,
  output logic [9:0]            tlb_w_asid,
  output logic [18:0]           tlb_w_vppn,
  output logic                  tlb_w_g,
  output logic [PT_W-1:0]       tlb_w_phytran0,
  output logic [PT_W-1:0]       tlb_w_phytran1,

  // flush port
  output logic                  tlb_fe,
  output logic [2:0]            tlb_f_op,
  output logic [9:0]            tlb_f_asid,
  output logic [18:0]           tlb_f_va
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  logic [1:0]            state_reg;
  logic [1:0]            state_next;

  // operand snapshot taken at accept
  logic [2:0]            op_code_reg;
  logic [4:0]            inv_op_reg;
  logic [9:0]            inv_asid_reg;
  logic [18:0]           inv_vppn_reg;
  logic [TLBNUMSIZE-1:0] index_reg;
  logic [5:0]            ps_reg;
  logic                  ne_reg;
  logic [9:0]            asid_reg;
  logic [18:0]           vppn_reg;
  logic                  g_reg;
  logic [PT_W-1:0]       pt0_reg;
  logic [PT_W-1:0]       pt1_reg;
  logic                  tlbrefill_reg;
  logic [TLBNUMSIZE-1:0] fill_cap_reg;

  // round-robin replacement pointer for TLBFILL
  logic [TLBNUMSIZE-1:0] fill_idx_reg;

  // results
  logic                  srch_hit_reg;
  logic [TLBNUMSIZE-1:0] srch_index_reg;
  logic [5:0]            rd_ps_reg;
  logic                  rd_ne_reg;
  logic [9:0]            rd_asid_reg;
  logic [18:0]           rd_vppn_reg;
  logic                  rd_g_reg;
  logic [PT_W-1:0]       rd_pt0_reg;
  logic [PT_W-1:0]       rd_pt1_reg;

  logic in_idle;
  logic in_exec;
  logic in_done;
  logic accept;
  logic is_srch;
  logic is_rd;
  logic is_write;
  logic is_inv;
  logic inv_legal;
  logic op_illegal;
  logic srch_exec;

  assign in_idle    = (state_reg == ST_IDLE);
  assign in_exec    = (state_reg == ST_EXEC);
  assign in_done    = (state_reg == ST_DONE);
  assign accept     = in_idle && ctl.op_valid;

  assign is_srch    = (op_code_reg == OP_SRCH);
  assign is_rd      = (op_code_reg == OP_RD);
  assign is_write   = (op_code_reg == OP_WR) || (op_code_reg == OP_FILL);
  assign is_inv     = (op_code_reg == OP_INV);
  assign inv_legal  = (inv_op_reg <= 5'd6);
  assign op_illegal = (op_code_reg > OP_INV);
  assign srch_exec  = in_exec && is_srch;

  // Every op takes exactly one execute cycle and one completion cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = ST_EXEC;
      ST_EXEC: state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State register; reset also aborts an op caught in EXEC.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Snapshot op and CSR operands so later CSR changes cannot disturb the op.
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_code_reg   <= '0;
      inv_op_reg    <= '0;
      inv_asid_reg  <= '0;
      inv_vppn_reg  <= '0;
      index_reg     <= '0;
      ps_reg        <= '0;
      ne_reg        <= 1'b0;
      asid_reg      <= '0;
      vppn_reg      <= '0;
      g_reg         <= 1'b0;
      pt0_reg       <= '0;
      pt1_reg       <= '0;
      tlbrefill_reg <= 1'b0;
      fill_cap_reg  <= '0;
    end else if (accept) begin
      op_code_reg   <= ctl.op_code;
      inv_op_reg    <= ctl.inv_op;
      inv_asid_reg  <= ctl.inv_asid;
      inv_vppn_reg  <= ctl.inv_vppn;
      index_reg     <= ctl.csr_index;
      ps_reg        <= ctl.csr_ps;
      ne_reg        <= ctl.csr_ne;
      asid_reg      <= ctl.csr_asid;
      vppn_reg      <= ctl.csr_vppn;
      g_reg         <= ctl.csr_g;
      pt0_reg       <= ctl.csr_pt0;
      pt1_reg       <= ctl.csr_pt1;
      tlbrefill_reg <= ctl.csr_tlbrefill;
      fill_cap_reg  <= fill_idx_reg;
    end
  end

  // Free-running fill pointer, wrapping at the last entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fill_idx_reg <= '0;
    end else if (fill_idx_reg == TLBNUMSIZE'(TLBNUM - 1)) begin
      fill_idx_reg <= '0;
    end else begin
      fill_idx_reg <= fill_idx_reg + 1'b1;
    end
  end

  // Latch search/read results at the end of EXEC so they appear with done.
  always_ff @(posedge clk) begin
    if (!reset) begin
      srch_hit_reg   <= 1'b0;
      srch_index_reg <= '0;
      rd_ps_reg      <= '0;
      rd_ne_reg      <= 1'b0;
      rd_asid_reg    <= '0;
      rd_vppn_reg    <= '0;
      rd_g_reg       <= 1'b0;
      rd_pt0_reg     <= '0;
      rd_pt1_reg     <= '0;
    end else begin
      if (srch_exec) begin
        srch_hit_reg   <= !tlb_s1_ne;
        srch_index_reg <= tlb_s1_index;
      end
      if (in_exec && is_rd) begin
        // An invalid entry reads back as NE with every other field cleared.
        rd_ne_reg <= tlb_r_ne;
        if (tlb_r_ne) begin
          rd_ps_reg   <= '0;
          rd_asid_reg <= '0;
          rd_vppn_reg <= '0;
          rd_g_reg    <= 1'b0;
          rd_pt0_reg  <= '0;
          rd_pt1_reg  <= '0;
        end else begin
          rd_ps_reg   <= tlb_r_ps;
          rd_asid_reg <= tlb_r_asid;
          rd_vppn_reg <= tlb_r_vppn;
          rd_g_reg    <= tlb_r_g;
          rd_pt0_reg  <= tlb_r_phytran0;
          rd_pt1_reg  <= tlb_r_phytran1;
        end
      end
    end
  end

  // Search port 1: TLBSRCH owns it during its execute cycle only.
  assign tlb_s1_vppn = srch_exec ? vppn_reg : mem_s_vppn;
  assign tlb_s1_asid = srch_exec ? asid_reg : mem_s_asid;
  assign tlb_s1_odd  = srch_exec ? 1'b0     : mem_s_odd;
  assign mem_s_stall = srch_exec && mem_s_valid;

  // Read port.
  assign tlb_r_index = index_reg;

  // Write port; a refill-exception write always produces a valid entry.
  assign tlb_we         = in_exec && is_write;
  assign tlb_w_index    = (op_code_reg == OP_FILL) ? fill_cap_reg : index_reg;
  assign tlb_w_ps       = ps_reg;
  assign tlb_w_ne       = ne_reg && !tlbrefill_reg;
  assign tlb_w_asid     = asid_reg;
  assign tlb_w_vppn     = vppn_reg;
  assign tlb_w_g        = g_reg;
  assign tlb_w_phytran0 = pt0_reg;
  assign tlb_w_phytran1 = pt1_reg;

  // Flush port.
  assign tlb_fe     = in_exec && is_inv && inv_legal;
  assign tlb_f_op   = inv_op_reg[2:0];
  assign tlb_f_asid = inv_asid_reg;
  assign tlb_f_va   = inv_vppn_reg;

  // Completion and results.
  assign ctl.op_ready   = in_idle;
  assign ctl.done       = in_done;
  assign ctl.err        = in_done && (op_illegal || (is_inv && !inv_legal));
  assign ctl.refetch    = in_done && (is_write || (is_inv && inv_legal));
  assign ctl.srch_hit   = srch_hit_reg;
  assign ctl.srch_index = srch_index_reg;
  assign ctl.rd_ps      = rd_ps_reg;
  assign ctl.rd_ne      = rd_ne_reg;
  assign ctl.rd_asid    = rd_asid_reg;
  assign ctl.rd_vppn    = rd_vppn_reg;
  assign ctl.rd_g       = rd_g_reg;
  assign ctl.rd_pt0     = rd_pt0_reg;
  assign ctl.rd_pt1     = rd_pt1_reg;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Bench for tlb_op_ctrl: the bench plays the TLB array (search/read/write/
// flush), keeps a transaction-level model of the sequencer, and compares the
// DUT against it every cycle; directed ops add literal expectations.
module tb_tlb_op_ctrl;
  localparam int NSZ  = 4;
  localparam int PT_W = 26;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  tlb_op_ctrl_if #(.TLBNUMSIZE(NSZ), .PT_W(PT_W)) ifc ();

  logic            mem_s_valid, mem_s_odd, mem_s_stall;
  logic [18:0]     mem_s_vppn;
  logic [9:0]      mem_s_asid;
  logic [18:0]     tlb_s1_vppn;
  logic [9:0]      tlb_s1_asid;
  logic            tlb_s1_odd;
  logic [NSZ-1:0]  tlb_s1_index;
  logic            tlb_s1_ne;
  logic [NSZ-1:0]  tlb_r_index;
  logic [5:0]      tlb_r_ps;
  logic [9:0]      tlb_r_asid;
  logic            tlb_r_ne, tlb_r_g;
  logic [18:0]     tlb_r_vppn;
  logic [PT_W-1:0] tlb_r_phytran0, tlb_r_phytran1;
  logic            tlb_we;
  logic [NSZ-1:0]  tlb_w_index;
  logic [5:0]      tlb_w_ps;
  logic            tlb_w_ne, tlb_w_g;
  logic [9:0]      tlb_w_asid;
  logic [18:0]     tlb_w_vppn;
  logic [PT_W-1:0] tlb_w_phytran0, tlb_w_phytran1;
  logic            tlb_fe;
  logic [2:0]      tlb_f_op;
  logic [9:0]      tlb_f_asid;
  logic [18:0]     tlb_f_va;

  tlb_op_ctrl #(.TLBNUM(16), .TLBNUMSIZE(NSZ), .PT_W(PT_W)) dut (
    .clk(clk), .reset(reset), .ctl(ifc),
    .mem_s_valid(mem_s_valid), .mem_s_vppn(mem_s_vppn), .mem_s_asid(mem_s_asid),
    .mem_s_odd(mem_s_odd), .mem_s_stall(mem_s_stall),
    .tlb_s1_vppn(tlb_s1_vppn), .tlb_s1_asid(tlb_s1_asid), .tlb_s1_odd(tlb_s1_odd),
    .tlb_s1_index(tlb_s1_index), .tlb_s1_ne(tlb_s1_ne),
    .tlb_r_index(tlb_r_index), .tlb_r_ps(tlb_r_ps), .tlb_r_asid(tlb_r_asid),
    .tlb_r_ne(tlb_r_ne), .tlb_r_g(tlb_r_g), .tlb_r_vppn(tlb_r_vppn),
    .tlb_r_phytran0(tlb_r_phytran0), .tlb_r_phytran1(tlb_r_phytran1),
    .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_ps(tlb_w_ps),
    .tlb_w_ne(tlb_w_ne), .tlb_w_asid(tlb_w_asid), .tlb_w_vppn(tlb_w_vppn),
    .tlb_w_g(tlb_w_g), .tlb_w_phytran0(tlb_w_phytran0), .tlb_w_phytran1(tlb_w_phytran1),
    .tlb_fe(tlb_fe), .tlb_f_op(tlb_f_op), .tlb_f_asid(tlb_f_asid), .tlb_f_va(tlb_f_va)
  );

  // ---------------- TLB array played by the bench ----------------
  typedef struct packed {
    logic            v;
    logic [18:0]     vppn;
    logic [9:0]      asid;
    logic            g;
    logic [5:0]      ps;
    logic [PT_W-1:0] pt0;
    logic [PT_W-1:0] pt1;
  } ent_t;

  ent_t tlb_mem [16];
  logic mem_init = 1'b0;

  function automatic logic ent_match(input ent_t e, input logic [18:0] vppn, input logic [9:0] asid);
    return e.v && (e.vppn == vppn) && (e.g || (e.asid == asid));
  endfunction

  // lowest matching index wins
  function automatic logic [4:0] lookup(input logic [18:0] vppn, input logic [9:0] asid);
    for (int i = 0; i < 16; i++)
      if (ent_match(tlb_mem[i], vppn, asid)) return {1'b1, 4'(i)};
    return 5'd0;
  endfunction

  function automatic logic flush_hit(input ent_t e, input logic [2:0] op,
                                     input logic [9:0] asid, input logic [18:0] va);
    case (op)
      3'd0, 3'd1: return 1'b1;
      3'd2:       return e.g;
      3'd3:       return !e.g;
      3'd4:       return !e.g && (e.asid == asid);
      3'd5:       return !e.g && (e.asid == asid) && (e.vppn == va);
      3'd6:       return (e.g || (e.asid == asid)) && (e.vppn == va);
      default:    return 1'b0;
    endcase
  endfunction

  always_comb begin
    tlb_s1_ne    = 1'b1;
    tlb_s1_index = '0;
    for (int i = 15; i >= 0; i--) begin
      if (ent_match(tlb_mem[i], tlb_s1_vppn, tlb_s1_asid)) begin
        tlb_s1_ne    = 1'b0;
        tlb_s1_index = 4'(i);
      end
    end
  end

  assign tlb_r_ne       = !tlb_mem[tlb_r_index].v;
  assign tlb_r_ps       = tlb_mem[tlb_r_index].ps;
  assign tlb_r_asid     = tlb_mem[tlb_r_index].asid;
  assign tlb_r_g        = tlb_mem[tlb_r_index].g;
  assign tlb_r_vppn     = tlb_mem[tlb_r_index].vppn;
  assign tlb_r_phytran0 = tlb_mem[tlb_r_index].pt0;
  assign tlb_r_phytran1 = tlb_mem[tlb_r_index].pt1;

  // ---------------- transaction-level model ----------------
  typedef struct packed {
    logic [2:0]      op;
    logic [4:0]      inv_op;
    logic [9:0]      inv_asid;
    logic [18:0]     inv_vppn;
    logic [3:0]      index;
    logic [5:0]      ps;
    logic            ne;
    logic [9:0]      asid;
    logic [18:0]     vppn;
    logic            g;
    logic [PT_W-1:0] pt0;
    logic [PT_W-1:0] pt1;
    logic            refill;
    logic [3:0]      fill;
  } tx_t;

  typedef struct packed {
    logic [5:0]      ps;
    logic            ne;
    logic [9:0]      asid;
    logic [18:0]     vppn;
    logic            g;
    logic [PT_W-1:0] pt0;
    logic [PT_W-1:0] pt1;
  } rd_t;

  tx_t        tx;
  int         age = 0;           // cycles since accept: 0 idle, 1 port action, 2 done
  logic [3:0] model_fill = 4'd0;
  logic       m_hit = 1'b0;
  logic [3:0] m_idx = 4'd0;
  rd_t        m_rd = '0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 16; i++)
        tlb_mem[i] <= '{v: 1'b0, vppn: 19'h7abcd ^ 19'(i), asid: 10'h155, g: 1'b1,
                        ps: 6'd12, pt0: 26'h2aaaaaa, pt1: 26'h1555555};
      mem_init <= 1'b1;
    end else begin
      if (tlb_we)
        tlb_mem[tlb_w_index] <= '{v: !tlb_w_ne, vppn: tlb_w_vppn, asid: tlb_w_asid, g: tlb_w_g,
                                  ps: tlb_w_ps, pt0: tlb_w_phytran0, pt1: tlb_w_phytran1};
      if (tlb_fe)
        for (int i = 0; i < 16; i++)
          if (flush_hit(tlb_mem[i], tlb_f_op, tlb_f_asid, tlb_f_va)) tlb_mem[i].v <= 1'b0;
    end

    model_fill <= (!reset) ? 4'd0 : ((model_fill == 4'd15) ? 4'd0 : model_fill + 4'd1);

    if (!reset) begin
      age   <= 0;
      m_hit <= 1'b0;
      m_idx <= 4'd0;
      m_rd  <= '0;
    end else if (age == 0) begin
      if (ifc.op_valid) begin
        tx <= '{op: ifc.op_code, inv_op: ifc.inv_op, inv_asid: ifc.inv_asid,
                inv_vppn: ifc.inv_vppn, index: ifc.csr_index, ps: ifc.csr_ps,
                ne: ifc.csr_ne, asid: ifc.csr_asid, vppn: ifc.csr_vppn, g: ifc.csr_g,
                pt0: ifc.csr_pt0, pt1: ifc.csr_pt1, refill: ifc.csr_tlbrefill,
                fill: model_fill};
        age <= 1;
      end
    end else if (age == 1) begin
      if (tx.op == 3'd0) begin
        m_hit <= lookup(tx.vppn, tx.asid) >> 4;
        m_idx <= lookup(tx.vppn, tx.asid);
      end
      if (tx.op == 3'd1) begin
        if (tlb_mem[tx.index].v)
          m_rd <= '{ps: tlb_mem[tx.index].ps, ne: 1'b0, asid: tlb_mem[tx.index].asid,
                    vppn: tlb_mem[tx.index].vppn, g: tlb_mem[tx.index].g,
                    pt0: tlb_mem[tx.index].pt0, pt1: tlb_mem[tx.index].pt1};
        else
          m_rd <= '{ps: 6'd0, ne: 1'b1, asid: 10'd0, vppn: 19'd0, g: 1'b0,
                    pt0: '0, pt1: '0};
      end
      age <= 2;
    end else begin
      age <= 0;
    end
  end

  // ---------------- checking ----------------
  int   n_vec  = 0;
  int   n_miss = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  logic exp_we, exp_fe, exp_srch, exp_ok_inv;
  assign exp_we     = (age == 1) && (tx.op == 3'd2 || tx.op == 3'd3);
  assign exp_ok_inv = (tx.op == 3'd4) && (tx.inv_op <= 5'd6);
  assign exp_fe     = (age == 1) && exp_ok_inv;
  assign exp_srch   = (age == 1) && (tx.op == 3'd0);

  always @(negedge clk) begin
    if (chk_en) begin
      chk("op_ready", ifc.op_ready, age == 0);
      chk("mem_s_stall", mem_s_stall, exp_srch && mem_s_valid);
      chk("s1_vppn", tlb_s1_vppn, exp_srch ? tx.vppn : mem_s_vppn);
      chk("s1_asid", tlb_s1_asid, exp_srch ? tx.asid : mem_s_asid);
      chk("s1_odd", tlb_s1_odd, exp_srch ? 1'b0 : mem_s_odd);
      chk("we", tlb_we, exp_we);
      chk("fe", tlb_fe, exp_fe);
      if (exp_we) begin
        chk("w_index", tlb_w_index, (tx.op == 3'd3) ? tx.fill : tx.index);
        chk("w_ne", tlb_w_ne, tx.ne && !tx.refill);
        chk("w_entry", {tlb_w_vppn, tlb_w_asid, tlb_w_g, tlb_w_ps},
            {tx.vppn, tx.asid, tx.g, tx.ps});
        chk("w_pt", {tlb_w_phytran0, tlb_w_phytran1}, {tx.pt0, tx.pt1});
      end
      if (exp_fe)
        chk("flush", {tlb_f_op, tlb_f_asid, tlb_f_va}, {tx.inv_op[2:0], tx.inv_asid, tx.inv_vppn});
      if (age == 1 && tx.op == 3'd1) chk("r_index", tlb_r_index, tx.index);
      chk("done", ifc.done, age == 2);
      chk("err", ifc.err, (age == 2) && ((tx.op > 3'd4) || (tx.op == 3'd4 && tx.inv_op > 5'd6)));
      chk("refetch", ifc.refetch, (age == 2) && (tx.op == 3'd2 || tx.op == 3'd3 || exp_ok_inv));
      chk("srch_hit", ifc.srch_hit, m_hit);
      if (m_hit) chk("srch_index", ifc.srch_index, m_idx);
      chk("rd_fields", {ifc.rd_ps, ifc.rd_ne, ifc.rd_asid, ifc.rd_vppn, ifc.rd_g},
          {m_rd.ps, m_rd.ne, m_rd.asid, m_rd.vppn, m_rd.g});
      chk("rd_pt", {ifc.rd_pt0, ifc.rd_pt1}, {m_rd.pt0, m_rd.pt1});
    end
  end

  // ---------------- stimulus ----------------
  logic mem_rand = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mem_rand) begin
        mem_s_valid = 1'($urandom_range(0, 1));
        mem_s_vppn  = 19'($urandom);
        mem_s_asid  = 10'($urandom);
        mem_s_odd   = 1'($urandom_range(0, 1));
      end
    end
  end

  // observations at N (accept cycle), N+1 (port action) and N+2 (done)
  logic           s0_stall, s1_stall, s2_stall;
  logic           s1_we, s1_fe, s1_wne, s1_done;
  logic [NSZ-1:0] s1_windex;
  logic [2:0]     s1_fop;
  logic           s2_done, s2_err, s2_refetch, s2_hit, s2_rd_ne;
  logic [NSZ-1:0] s2_idx;
  logic [9:0]     s2_rd_asid;
  logic [18:0]    s2_rd_vppn;

  task automatic do_op(input logic [2:0] code, input logic [3:0] idx, input logic [18:0] vppn,
                       input logic [9:0] asid, input logic g, input logic ne, input logic refill,
                       input logic [4:0] iop, input logic [9:0] iasid, input logic [18:0] ivppn,
                       input int wait_fill);
    int guard = 0;
    while (!ifc.op_ready && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!ifc.op_ready) chk("op_ready_timeout", 1'b0, 1'b1);
    guard = 0;
    while (wait_fill >= 0 && model_fill != 4'(wait_fill) && guard < 40) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (wait_fill >= 0 && model_fill != 4'(wait_fill)) chk("fill_wait_timeout", 1'b0, 1'b1);
    ifc.op_code       = code;
    ifc.csr_index     = idx;
    ifc.csr_vppn      = vppn;
    ifc.csr_asid      = asid;
    ifc.csr_g         = g;
    ifc.csr_ne        = ne;
    ifc.csr_tlbrefill = refill;
    ifc.csr_ps        = 6'($urandom_range(12, 21));
    ifc.csr_pt0       = 26'($urandom);
    ifc.csr_pt1       = 26'($urandom);
    ifc.inv_op        = iop;
    ifc.inv_asid      = iasid;
    ifc.inv_vppn      = ivppn;
    ifc.op_valid      = 1'b1;
    @(negedge clk);
    s0_stall = mem_s_stall;
    @(posedge clk);
    #1;
    ifc.op_valid = 1'b0;
    @(negedge clk);
    s1_stall  = mem_s_stall;
    s1_we     = tlb_we;
    s1_fe     = tlb_fe;
    s1_wne    = tlb_w_ne;
    s1_windex = tlb_w_index;
    s1_fop    = tlb_f_op;
    s1_done   = ifc.done;
    @(negedge clk);
    s2_stall   = mem_s_stall;
    s2_done    = ifc.done;
    s2_err     = ifc.err;
    s2_refetch = ifc.refetch;
    s2_hit     = ifc.srch_hit;
    s2_idx     = ifc.srch_index;
    s2_rd_ne   = ifc.rd_ne;
    s2_rd_asid = ifc.rd_asid;
    s2_rd_vppn = ifc.rd_vppn;
    @(posedge clk);
    #1;
  endtask

  logic [18:0] pool [4];

  initial begin
    pool[0] = 19'h12345; pool[1] = 19'h0abcd; pool[2] = 19'h00001; pool[3] = 19'h7ffff;
    ifc.op_valid = 1'b0; ifc.op_code = '0; ifc.inv_op = '0; ifc.inv_asid = '0;
    ifc.inv_vppn = '0; ifc.csr_index = '0; ifc.csr_ps = '0; ifc.csr_ne = 1'b0;
    ifc.csr_asid = '0; ifc.csr_vppn = '0; ifc.csr_g = 1'b0; ifc.csr_pt0 = '0;
    ifc.csr_pt1 = '0; ifc.csr_tlbrefill = 1'b0;
    mem_s_valid = 1'b1; mem_s_vppn = 19'h55555; mem_s_asid = 10'h3; mem_s_odd = 1'b1;

    // reset state
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_done_err_refetch", {ifc.done, ifc.err, ifc.refetch}, 3'b000);
    chk("rst_we_fe_stall", {tlb_we, tlb_fe, mem_s_stall}, 3'b000);
    chk("rst_results", {ifc.srch_hit, ifc.srch_index, ifc.rd_ne, ifc.rd_asid, ifc.rd_vppn}, '0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", ifc.op_ready, 1'b1);
    @(posedge clk);
    #1;

    // install entry 7 then TLBSRCH it with a MEM lookup pending throughout
    do_op(3'd2, 4'd7, 19'h12345, 10'd5, 1'b0, 1'b0, 1'b0, 5'd0, 10'd0, 19'd0, -1);
    chk("wr7_we", s1_we, 1'b1);
    chk("wr7_index", s1_windex, 4'd7);
    chk("wr7_refetch", s2_refetch, 1'b1);
    do_op(3'd0, 4'd0, 19'h12345, 10'd5, 1'b0, 1'b0, 1'b0, 5'd0, 10'd0, 19'd0, -1);
    chk("srch_stall_n", s0_stall, 1'b0);
    chk("srch_stall_n1", s1_stall, 1'b1);
    chk("srch_stall_n2", s2_stall, 1'b0);
    chk("srch_done_n1", s1_done, 1'b0);
    chk("srch_done_n2", s2_done, 1'b1);
    chk("srch_hit_lit", s2_hit, 1'b1);
    chk("srch_index_lit", s2_idx, 4'd7);

    // TLBRD of an invalid entry holding stale fields
    do_op(3'd1, 4'd3, 19'd0, 10'd0, 1'b0, 1'b0, 1'b0, 5'd0, 10'd0, 19'd0, -1);
    chk("rd_inv_ne", s2_rd_ne, 1'b1);
    chk("rd_inv_asid", s2_rd_asid, 10'd0);
    chk("rd_inv_vppn", s2_rd_vppn, 19'd0);
    chk("rd_inv_done", s2_done, 1'b1);
    chk("rd_inv_refetch", s2_refetch, 1'b0);

    // TLBWR during refill forces a valid entry, then search finds it
    do_op(3'd2, 4'd2, 19'h0abcd, 10'd9, 1'b0, 1'b1, 1'b1, 5'd0, 10'd0, 19'd0, -1);
    chk("wr2_wne", s1_wne, 1'b0);
    chk("wr2_refetch", s2_refetch, 1'b1);
    do_op(3'd0, 4'd0, 19'h0abcd, 10'd9, 1'b0, 1'b0, 1'b0, 5'd0, 10'd0, 19'd0, -1);
    chk("srch2_hit", s2_hit, 1'b1);
    chk("srch2_index", s2_idx, 4'd2);

    // FILL at pointer 15, then back-to-back FILL three cycles later sees 2
    do_op(3'd3, 4'd0, 19'h00001, 10'd1, 1'b0, 1'b0, 1'b0, 5'd0, 10'd0, 19'd0, 15);
    chk("fill15_index", s1_windex, 4'd15);
    do_op(3'd3, 4'd0, 19'h00002, 10'd1, 1'b0, 1'b0, 1'b0, 5'd0, 10'd0, 19'd0, -1);
    chk("fill_wrap_index", s1_windex, 4'd2);

    // INVTLB legal/illegal and an illegal op_code
    do_op(3'd4, 4'd0, 19'd0, 10'd0, 1'b0, 1'b0, 1'b0, 5'd2, 10'd0, 19'd0, -1);
    chk("inv2_fe", s1_fe, 1'b1);
    chk("inv2_fop", s1_fop, 3'd2);
    chk("inv2_refetch", s2_refetch, 1'b1);
    chk("inv2_err", s2_err, 1'b0);
    do_op(3'd4, 4'd0, 19'd0, 10'd0, 1'b0, 1'b0, 1'b0, 5'd9, 10'd0, 19'd0, -1);
    chk("inv9_fe", s1_fe, 1'b0);
    chk("inv9_err", s2_err, 1'b1);
    chk("inv9_refetch", s2_refetch, 1'b0);
    do_op(3'd6, 4'd0, 19'd0, 10'd0, 1'b0, 1'b0, 1'b0, 5'd0, 10'd0, 19'd0, -1);
    chk("op6_done", s2_done, 1'b1);
    chk("op6_err", s2_err, 1'b1);
    chk("op6_quiet", {s1_we, s1_fe}, 2'b00);

    // reset sampled while a TLBWR is in EXEC
    ifc.op_code = 3'd2; ifc.csr_index = 4'd4; ifc.csr_ne = 1'b0;
    ifc.op_valid = 1'b1;
    @(posedge clk);
    #1;
    ifc.op_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_we", tlb_we, 1'b0);
    chk("abort_done", ifc.done, 1'b0);
    chk("abort_ready", ifc.op_ready, 1'b1);
    @(negedge clk);
    chk("abort_done_later", ifc.done, 1'b0);
    @(posedge clk);
    #1;

    // randomized ops with random MEM lookup traffic
    mem_rand = 1'b1;
    repeat (200) begin
      do_op(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), pool[$urandom_range(0, 3)],
            10'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 9)), 10'($urandom_range(0, 3)),
            pool[$urandom_range(0, 3)], -1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
